capture_ctrl: RTL

Parametrised capture controller for the logic analyzer sample pipeline. It sits after the RLE encoder and replaces the fixed-size controller with a circular-buffer engine. Width, depth, pre-trigger history, post-trigger length and abort are all runtime- or build-configurable. Readback is a valid/ready stream with an end-of-capture marker, so it no longer depends on a busy/send pair.

---
 rtl/capture_ctrl_pkg.sv | 20 ++
 rtl/capture_rd_port.sv | 116 +++++++++++
 rtl/capture_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg
// Shared definitions for the capture controller and its readback port.
//   state_t     : controller state encoding (IDLE=0, ARMED=1, POST=2, READ=3)
//   count_width : width of sample counters that must hold the value 2^AW
package capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Counters such as fill and the readback length must represent a full
    // buffer (2^AW), which takes one bit more than an address.
    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/capture_rd_port.sv
// capture_rd_port
// Readback engine of the capture controller. On start it computes the
// readback length (min of requested count and buffer fill) and the address
// of the oldest sample, then streams samples oldest first over a
// valid/ready interface with one memory read in flight at most.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start              : pulse in the cycle the controller decides to enter READ
//   start_fill         : buffer fill including any write in the start cycle
//   start_wptr         : write pointer after any write in the start cycle
//   cfg_read           : latched number of samples requested
//   start_empty        : combinational, high with start when the length is 0
//   empty              : registered, high in the first READ cycle of a 0-length readback
//   finish             : combinational, handshake of the final sample
//   mem_rd/mem_raddr   : memory read strobe/address, data returns one cycle later
//   mem_rdata          : memory read data
//   sto_valid/sto_data/sto_last/sto_ready : readback stream
module capture_rd_port
    import capture_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic [AW:0]   start_fill,
    input  logic [AW-1:0] start_wptr,
    input  logic [AW:0]   cfg_read,
    output logic          start_empty,
    output logic          empty,
    output logic          finish,
    output logic          mem_rd,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          sto_valid,
    output logic [DW-1:0] sto_data,
    output logic          sto_last,
    input  logic          sto_ready
);

    localparam int CW = count_width(AW);

    logic [CW-1:0] len;
    logic [CW-1:0] remain_reg;
    logic [AW-1:0] raddr_reg;
    logic          settle_reg;
    logic          cap_reg;
    logic          cap_last_reg;
    logic          empty_reg;
    logic          sto_valid_reg;
    logic [DW-1:0] sto_data_reg;
    logic          sto_last_reg;
    logic          issue;

    always_comb begin
        len = (cfg_read < start_fill) ? cfg_read : start_fill;
    end

    assign start_empty = start && (len == '0);

    // A new read is allowed only when the previous one has been captured and
    // the output register is free (or being freed this cycle). settle_reg
    // holds off the first read one cycle so the final capture write has
    // reached the memory before it may be read back.
    assign issue = (remain_reg != '0) && !settle_reg && !cap_reg &&
                   (!sto_valid_reg || sto_ready);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            remain_reg    <= '0;
            raddr_reg     <= '0;
            settle_reg    <= 1'b0;
            cap_reg       <= 1'b0;
            cap_last_reg  <= 1'b0;
            empty_reg     <= 1'b0;
            sto_valid_reg <= 1'b0;
            sto_data_reg  <= '0;
            sto_last_reg  <= 1'b0;
        end else begin
            cap_reg    <= issue;
            settle_reg <= start;
            if (start) begin
                remain_reg <= len;
                // Oldest sample sits len entries behind the write pointer.
                raddr_reg  <= start_wptr - len[AW-1:0];
                empty_reg  <= (len == '0);
            end else begin
                empty_reg <= 1'b0;
                if (issue) begin
                    remain_reg   <= remain_reg - CW'(1);
                    raddr_reg    <= raddr_reg + AW'(1);
                    cap_last_reg <= (remain_reg == CW'(1));
                end
            end

            if (cap_reg) begin
                sto_valid_reg <= 1'b1;
                sto_data_reg  <= mem_rdata;
                sto_last_reg  <= cap_last_reg;
            end else if (sto_valid_reg && sto_ready) begin
                sto_valid_reg <= 1'b0;
                sto_last_reg  <= 1'b0;
            end
        end
    end

    assign empty     = empty_reg;
    assign finish    = sto_valid_reg && sto_ready && sto_last_reg;
    assign mem_rd    = issue;
    assign mem_raddr = raddr_reg;
    assign sto_valid = sto_valid_reg;
    assign sto_data  = sto_data_reg;
    assign sto_last  = sto_last_reg;

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl
// Circular-buffer capture controller. After arm, samples are written into a
// 2^AW entry buffer continuously; run starts a post-trigger countdown, and
// when it expires (or on abort) the most recent samples are streamed back
// oldest first.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   arm, run, abort    : control pulses (start capture / trigger / finish now)
//   cfg_delay          : post-trigger sample count, latched at arm
//   cfg_read           : samples to read back, latched at arm
//   sti_valid/sti_data : input sample stream
//   mem_wr/mem_waddr/mem_wdata : registered memory write port
//   mem_rd/mem_raddr/mem_rdata : memory read port, 1-cycle read latency
//   sto_valid/sto_data/sto_last/sto_ready : readback stream
//   armed, triggered, done : registered status (done is a one-cycle pulse)
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          arm,
    input  logic          run,
    input  logic          abort,
    input  logic [AW:0]   cfg_delay,
    input  logic [AW:0]   cfg_read,
    input  logic          sti_valid,
    input  logic [DW-1:0] sti_data,
    output logic          mem_wr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          sto_valid,
    output logic [DW-1:0] sto_data,
    output logic          sto_last,
    input  logic          sto_ready,
    output logic          armed,
    output logic          triggered,
    output logic          done
);

    localparam int CW = count_width(AW);
    localparam logic [CW-1:0] FULL = {1'b1, {AW{1'b0}}};

    state_t        state_reg, state_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [CW-1:0] fill_reg, fill_next;
    logic [CW-1:0] post_reg, post_next;
    logic [CW-1:0] delay_reg, read_reg;
    logic          mem_wr_reg;
    logic [AW-1:0] mem_waddr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic          armed_reg, triggered_reg, done_reg;
    logic          accept;
    logic          rd_start;
    logic          done_next;
    logic          rd_start_empty, rd_empty, rd_finish;

    assign accept = sti_valid && ((state_reg == ST_ARMED) || (state_reg == ST_POST));

    always_comb begin
        state_next = state_reg;
        wptr_next  = wptr_reg;
        fill_next  = fill_reg;
        post_next  = post_reg;

        if (accept) begin
            wptr_next = wptr_reg + AW'(1);
            if (fill_reg != FULL) begin
                fill_next = fill_reg + CW'(1);
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (arm) begin
                    state_next = ST_ARMED;
                    fill_next  = '0;
                end
            end
            ST_ARMED: begin
                // abort outranks run; a sample in this cycle is pre-trigger.
                if (abort) begin
                    state_next = ST_READ;
                end else if (run) begin
                    if (delay_reg == '0) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_POST;
                        post_next  = delay_reg;
                    end
                end
            end
            ST_POST: begin
                if (abort) begin
                    state_next = ST_READ;
                end else if (accept) begin
                    post_next = post_reg - CW'(1);
                    if (post_reg == CW'(1)) begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rd_finish || rd_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        rd_start  = (state_reg != ST_READ) && (state_next == ST_READ);
        done_next = rd_start_empty || rd_finish;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= ST_IDLE;
            wptr_reg      <= '0;
            fill_reg      <= '0;
            post_reg      <= '0;
            delay_reg     <= '0;
            read_reg      <= '0;
            mem_wr_reg    <= 1'b0;
            mem_waddr_reg <= '0;
            mem_wdata_reg <= '0;
            armed_reg     <= 1'b0;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            wptr_reg  <= wptr_next;
            fill_reg  <= fill_next;
            post_reg  <= post_next;
            if ((state_reg == ST_IDLE) && arm) begin
                delay_reg <= cfg_delay;
                read_reg  <= cfg_read;
            end
            mem_wr_reg <= accept;
            if (accept) begin
                mem_waddr_reg <= wptr_reg;
                mem_wdata_reg <= sti_data;
            end
            armed_reg     <= (state_next == ST_ARMED) || (state_next == ST_POST);
            triggered_reg <= (state_next == ST_POST) || (state_next == ST_READ);
            done_reg      <= done_next;
        end
    end

    // The read port sees the post-write fill and pointer so a sample written
    // in the cycle READ is decided on is part of the readback.
    capture_rd_port #(
        .DW (DW),
        .AW (AW)
    ) u_rd_port (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (rd_start),
        .start_fill  (fill_next),
        .start_wptr  (wptr_next),
        .cfg_read    (read_reg),
        .start_empty (rd_start_empty),
        .empty       (rd_empty),
        .finish      (rd_finish),
        .mem_rd      (mem_rd),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .sto_valid   (sto_valid),
        .sto_data    (sto_data),
        .sto_last    (sto_last),
        .sto_ready   (sto_ready)
    );

    assign mem_wr    = mem_wr_reg;
    assign mem_waddr = mem_waddr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign armed     = armed_reg;
    assign triggered = triggered_reg;
    assign done      = done_reg;

endmodule
